tune_loader: RTL and testbench



---
 rtl/tx_pkg.sv | 42 ++++
 rtl/frame_timer.sv | 33 +++
 rtl/tune_loader.sv | 176 +++++++++++++++++
 tb/tb_tune_loader.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_pkg.sv
// Shared definitions for the transmitter control path: command codes, frame
// parser states and the frame checksum helper.
package tx_pkg;

    localparam logic [7:0] CMD_SET_FREQ      = 8'h01;
    localparam logic [7:0] CMD_SET_EN        = 8'h02;
    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_HUNT     = 3'd0,
        ST_CMD      = 3'd1,
        ST_PAY0     = 3'd2,
        ST_PAY1     = 3'd3,
        ST_CSUM     = 3'd4,
        ST_COMMIT_F = 3'd5,
        ST_COMMIT_R = 3'd6
    } state_t;

    // Checksum covers the command and every payload byte, never the sync byte.
    function automatic logic [7:0] frame_csum(input logic [7:0] cmd,
                                              input logic [7:0] p0,
                                              input logic [7:0] p1);
        logic [7:0] sum;
        sum = cmd ^ p0;
        if (cmd == CMD_SET_FREQ) begin
            sum = sum ^ p1;
        end else begin
            sum = sum ^ 8'h00;
        end
        return sum;
    endfunction

    function automatic logic in_frame(input state_t s);
        logic hit;
        case (s)
            ST_CMD, ST_PAY0, ST_PAY1, ST_CSUM: hit = 1'b1;
            default:                           hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/frame_timer.sv
// Inter-byte watchdog: counts cycles while a frame is open and flags the last
// permitted cycle so the parser can abandon a stalled frame.
module frame_timer #(
    parameter int TIMEOUT = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic expire
);

    localparam int              CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count_r;

    // Cycle counter; holds at LAST so it can never wrap back into range.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            count_r <= {CNT_W{1'b0}};
        end else if (run && (count_r != LAST)) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expire = run && (count_r == LAST);

endmodule

// File: rtl/tune_loader.sv
// Host-link frame parser that loads the NCO increment registers and gates the
// accumulator enable so a half-updated increment is never accumulated.
module tune_loader
    import tx_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE,
    parameter int         TIMEOUT   = 50000,
    parameter int         ERR_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic [7:0]       data,
    output logic             wr_divf,
    output logic             wr_divr,
    output logic             acc_en,
    output logic             frame_ok,
    output logic [ERR_W-1:0] err_cnt
);

    state_t           state_r;
    logic [7:0]       cmd_r;
    logic [7:0]       p0_r;
    logic [7:0]       p1_r;
    logic             en_r;
    logic [7:0]       data_r;
    logic             wr_divf_r;
    logic             wr_divr_r;
    logic             frame_ok_r;
    logic             acc_en_r;
    logic             rx_ready_r;
    logic [ERR_W-1:0] err_cnt_r;

    logic             accept_s;
    logic             timer_clear_s;
    logic             timer_run_s;
    logic             expire_s;
    logic [7:0]       csum_exp_s;
    logic [ERR_W-1:0] err_next_s;

    assign accept_s      = rx_valid && rx_ready_r;
    assign timer_clear_s = accept_s || (state_r == ST_HUNT);
    assign timer_run_s   = in_frame(state_r);
    assign csum_exp_s    = frame_csum(cmd_r, p0_r, p1_r);

    frame_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_frame_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (timer_clear_s),
        .run    (timer_run_s),
        .expire (expire_s)
    );

    // Saturating error increment.
    always_comb begin
        err_next_s = err_cnt_r;
        if (err_cnt_r == {ERR_W{1'b1}}) begin
            err_next_s = err_cnt_r;
        end else begin
            err_next_s = err_cnt_r + ERR_W'(1);
        end
    end

    // Frame parser FSM with registered accumulator-side outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_HUNT;
            cmd_r      <= 8'h00;
            p0_r       <= 8'h00;
            p1_r       <= 8'h00;
            en_r       <= 1'b0;
            data_r     <= 8'h00;
            wr_divf_r  <= 1'b0;
            wr_divr_r  <= 1'b0;
            frame_ok_r <= 1'b0;
            acc_en_r   <= 1'b0;
            rx_ready_r <= 1'b1;
            err_cnt_r  <= {ERR_W{1'b0}};
        end else begin
            wr_divf_r  <= 1'b0;
            wr_divr_r  <= 1'b0;
            frame_ok_r <= 1'b0;
            case (state_r)
                ST_HUNT: begin
                    if (accept_s && (rx_data == SYNC_BYTE)) begin
                        state_r <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (accept_s) begin
                        if ((rx_data == CMD_SET_FREQ) || (rx_data == CMD_SET_EN)) begin
                            cmd_r   <= rx_data;
                            state_r <= ST_PAY0;
                        end else begin
                            state_r   <= ST_HUNT;
                            err_cnt_r <= err_next_s;
                        end
                    end else if (expire_s) begin
                        state_r   <= ST_HUNT;
                        err_cnt_r <= err_next_s;
                    end
                end
                ST_PAY0: begin
                    if (accept_s) begin
                        p0_r    <= rx_data;
                        state_r <= (cmd_r == CMD_SET_FREQ) ? ST_PAY1 : ST_CSUM;
                    end else if (expire_s) begin
                        state_r   <= ST_HUNT;
                        err_cnt_r <= err_next_s;
                    end
                end
                ST_PAY1: begin
                    if (accept_s) begin
                        p1_r    <= rx_data;
                        state_r <= ST_CSUM;
                    end else if (expire_s) begin
                        state_r   <= ST_HUNT;
                        err_cnt_r <= err_next_s;
                    end
                end
                ST_CSUM: begin
                    if (accept_s) begin
                        if (rx_data != csum_exp_s) begin
                            state_r   <= ST_HUNT;
                            err_cnt_r <= err_next_s;
                        end else if (cmd_r == CMD_SET_FREQ) begin
                            // Pause the accumulator for both increment writes.
                            state_r    <= ST_COMMIT_F;
                            data_r     <= p1_r;
                            wr_divf_r  <= 1'b1;
                            acc_en_r   <= 1'b0;
                            rx_ready_r <= 1'b0;
                        end else begin
                            state_r    <= ST_HUNT;
                            en_r       <= p0_r[0];
                            acc_en_r   <= p0_r[0];
                            frame_ok_r <= 1'b1;
                        end
                    end else if (expire_s) begin
                        state_r   <= ST_HUNT;
                        err_cnt_r <= err_next_s;
                    end
                end
                ST_COMMIT_F: begin
                    state_r    <= ST_COMMIT_R;
                    data_r     <= p0_r;
                    wr_divr_r  <= 1'b1;
                    frame_ok_r <= 1'b1;
                end
                ST_COMMIT_R: begin
                    state_r    <= ST_HUNT;
                    acc_en_r   <= en_r;
                    rx_ready_r <= 1'b1;
                end
                default: begin
                    state_r    <= ST_HUNT;
                    acc_en_r   <= en_r;
                    rx_ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign rx_ready = rx_ready_r;
    assign data     = data_r;
    assign wr_divf  = wr_divf_r;
    assign wr_divr  = wr_divr_r;
    assign acc_en   = acc_en_r;
    assign frame_ok = frame_ok_r;
    assign err_cnt  = err_cnt_r;

endmodule

// File: tb/tb_tune_loader.sv
// Scoreboard bench for tune_loader: directed frames push expected accumulator
// events, a negedge monitor pops and compares them as the DUT emits strobes.
module tb_tune_loader;

    localparam int TIMEOUT = 8;
    localparam int ERR_W   = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [7:0]       rx_data = 8'h00;
    logic             rx_valid = 1'b0;
    logic             rx_ready;
    logic [7:0]       data;
    logic             wr_divf;
    logic             wr_divr;
    logic             acc_en;
    logic             frame_ok;
    logic [ERR_W-1:0] err_cnt;

    // kind: 1 = fine write, 2 = coarse write + frame_ok, 3 = enable frame_ok
    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] data;
        logic       acc;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;
    logic [1:0] mon_kind;
    int checks   = 0;
    int failures = 0;

    tune_loader #(
        .SYNC_BYTE (8'hA5),
        .TIMEOUT   (TIMEOUT),
        .ERR_W     (ERR_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .data     (data),
        .wr_divf  (wr_divf),
        .wr_divr  (wr_divr),
        .acc_en   (acc_en),
        .frame_ok (frame_ok),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!rx_ready) begin
            checks++;
            failures++;
            $display("FAIL send_byte: rx_ready stuck low for byte %0h, expected 1", b);
        end else begin
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b0;
    endtask

    task automatic send4(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
        send_byte(a); send_byte(b); send_byte(c); send_byte(d);
    endtask

    task automatic push(input logic [1:0] k, input logic [7:0] d, input logic acc);
        ev_t e;
        e.kind = k; e.data = d; e.acc = acc;
        exp_q.push_back(e);
    endtask

    // Monitor: every strobe or frame_ok pulse must match the next expected event.
    always @(negedge clk) begin
        if (rst_n && (wr_divf || wr_divr || frame_ok)) begin
            check("strobe_exclusive", {31'd0, wr_divf & wr_divr}, 32'd0);
            mon_kind = wr_divf ? 2'd1 : (wr_divr ? 2'd2 : 2'd3);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_event: got kind %0d data %0h, expected none", mon_kind, data);
            end else begin
                mon_e = exp_q.pop_front();
                check("event_kind", {30'd0, mon_kind}, {30'd0, mon_e.kind});
                check("event_acc_en", {31'd0, acc_en}, {31'd0, mon_e.acc});
                check("event_rx_ready", {31'd0, rx_ready}, {31'd0, (mon_e.kind == 2'd3)});
                if (mon_e.kind != 2'd3) begin
                    check("event_data", {24'd0, data}, {24'd0, mon_e.data});
                    check("event_frame_ok", {31'd0, frame_ok}, {31'd0, (mon_e.kind == 2'd2)});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with a sync byte on the link: nothing must move.
        rx_valid = 1'b1;
        rx_data  = 8'hA5;
        idle(3);
        check("rst_data", {24'd0, data}, 32'h0);
        check("rst_wr_divf", {31'd0, wr_divf}, 32'd0);
        check("rst_wr_divr", {31'd0, wr_divr}, 32'd0);
        check("rst_acc_en", {31'd0, acc_en}, 32'd0);
        check("rst_frame_ok", {31'd0, frame_ok}, 32'd0);
        check("rst_err_cnt", {30'd0, err_cnt}, 32'd0);
        check("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
        rx_valid = 1'b0;
        rst_n    = 1'b1;
        idle(2);

        // Enable, then a SET_FREQ with the 2-cycle accumulator pause.
        push(2'd3, 8'h00, 1'b1);
        send4(8'hA5, 8'h02, 8'h01, 8'h03);
        idle(1);
        check("en_on", {31'd0, acc_en}, 32'd1);
        push(2'd1, 8'h34, 1'b0);
        push(2'd2, 8'h12, 1'b0);
        send4(8'hA5, 8'h01, 8'h12, 8'h34);
        send_byte(8'h27);
        check("commit_f_acc_en", {31'd0, acc_en}, 32'd0);
        check("commit_f_rx_ready", {31'd0, rx_ready}, 32'd0);
        idle(1);
        check("commit_r_acc_en", {31'd0, acc_en}, 32'd0);
        idle(1);
        check("resume_acc_en", {31'd0, acc_en}, 32'd1);
        check("resume_rx_ready", {31'd0, rx_ready}, 32'd1);
        idle(2);
        check("data_hold", {24'd0, data}, 32'h12);

        // Bad checksum, then a good frame goes through normally.
        send4(8'hA5, 8'h01, 8'h12, 8'h34);
        send_byte(8'h00);
        idle(1);
        check("bad_csum_err", {30'd0, err_cnt}, 32'd1);
        check("bad_csum_acc_en", {31'd0, acc_en}, 32'd1);
        push(2'd1, 8'h56, 1'b0);
        push(2'd2, 8'h78, 1'b0);
        send4(8'hA5, 8'h01, 8'h78, 8'h56);
        send_byte(8'h2F);
        idle(3);
        check("after_bad_data", {24'd0, data}, 32'h78);

        // Garbage dropped, unknown command rejected, then disable.
        send4(8'h00, 8'hFF, 8'hA5, 8'h07);
        idle(1);
        check("unknown_cmd_err", {30'd0, err_cnt}, 32'd2);
        push(2'd3, 8'h00, 1'b0);
        send4(8'hA5, 8'h02, 8'h00, 8'h02);
        idle(1);
        check("en_off", {31'd0, acc_en}, 32'd0);

        // SET_FREQ while disabled: acc_en stays low throughout.
        push(2'd1, 8'h0F, 1'b0);
        push(2'd2, 8'hF0, 1'b0);
        send4(8'hA5, 8'h01, 8'hF0, 8'h0F);
        send_byte(8'hFE);
        idle(2);
        check("dis_freq_acc_en", {31'd0, acc_en}, 32'd0);

        // Byte on the expiry cycle wins over the timeout.
        push(2'd1, 8'hAA, 1'b0);
        push(2'd2, 8'h55, 1'b0);
        send_byte(8'hA5);
        send_byte(8'h01);
        idle(TIMEOUT - 1);
        send_byte(8'h55);
        send_byte(8'hAA);
        send_byte(8'hFE);
        idle(3);
        check("expiry_byte_err", {30'd0, err_cnt}, 32'd2);

        // Plain timeout: still open one cycle early, aborted on the last.
        send_byte(8'hA5);
        send_byte(8'h01);
        idle(TIMEOUT - 1);
        check("timeout_early_err", {30'd0, err_cnt}, 32'd2);
        idle(1);
        check("timeout_err", {30'd0, err_cnt}, 32'd3);
        push(2'd3, 8'h00, 1'b1);
        send4(8'hA5, 8'h02, 8'h01, 8'h03);
        idle(1);
        check("timeout_then_en", {31'd0, acc_en}, 32'd1);

        // Saturation from a fresh reset.
        rst_n = 1'b0;
        idle(1);
        check("rst2_err", {30'd0, err_cnt}, 32'd0);
        rst_n = 1'b1;
        idle(1);
        for (int i = 0; i < 5; i++) begin
            send4(8'hA5, 8'h02, 8'h01, 8'h00);
            idle(1);
            check("sat_err", {30'd0, err_cnt}, (i < 3) ? (i + 1) : 3);
        end

        // Asynchronous reset in the middle of COMMIT_F.
        push(2'd3, 8'h00, 1'b1);
        send4(8'hA5, 8'h02, 8'h01, 8'h03);
        idle(1);
        check("pre_async_acc_en", {31'd0, acc_en}, 32'd1);
        send4(8'hA5, 8'h01, 8'h12, 8'h34);
        send_byte(8'h27);
        check("pre_async_wr_divf", {31'd0, wr_divf}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_wr_divf", {31'd0, wr_divf}, 32'd0);
        check("async_acc_en", {31'd0, acc_en}, 32'd0);
        check("async_data", {24'd0, data}, 32'h0);
        idle(2);
        rst_n = 1'b1;
        idle(3);
        check("queue_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
